// File: rtl/aes_pkg.sv
// Shared AES constants and helpers: forward/inverse S-boxes, GF(2^8) arithmetic,
// round-count derivation and the decrypt FSM state type.
package aes_pkg;

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        FINAL
    } dec_state_e;

    function automatic logic [7:0] sub_byte(input logic [7:0] b);
        return SBOX[b];
    endfunction

    function automatic logic [7:0] inv_sub_byte(input logic [7:0] b);
        return INV_SBOX[b];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiply by a 4-bit constant; enough for the 9/11/13/14 InvMixColumns terms.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] m);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 4; i++) begin
            if (m[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic int nr_from_nk(input int nk);
        return nk + 6;
    endfunction

endpackage

// File: rtl/aes_decrypt_core_if.sv
// Block handshake and data bus of the AES decrypt core; NR sizes the key schedule.
interface aes_decrypt_core_if #(parameter int NR = 14);
    logic                    start;
    logic                    ready;
    logic                    done;
    logic [127:0]            in;
    logic [127:0]            out;
    logic [128*(NR+1)-1:0]   w;

    modport master (output start, in, w, input ready, done, out);
    modport slave  (input start, in, w, output ready, done, out);
endinterface

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey,
// then InvMixColumns unless is_last.
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [127:0] state,
    input  logic [127:0] round_key,
    input  logic         is_last,
    output logic [127:0] result
);

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {gmul(a0, 4'd14) ^ gmul(a1, 4'd11) ^ gmul(a2, 4'd13) ^ gmul(a3, 4'd9),
                gmul(a0, 4'd9)  ^ gmul(a1, 4'd14) ^ gmul(a2, 4'd11) ^ gmul(a3, 4'd13),
                gmul(a0, 4'd13) ^ gmul(a1, 4'd9)  ^ gmul(a2, 4'd14) ^ gmul(a3, 4'd11),
                gmul(a0, 4'd11) ^ gmul(a1, 4'd13) ^ gmul(a2, 4'd9)  ^ gmul(a3, 4'd14)};
    endfunction

    logic [127:0] ark;

    always_comb begin
        ark    = '0;
        result = '0;
        // Byte k = row + 4*col; row r rotates right by r on the inverse shift.
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                ark[127-8*(r+4*c) -: 8] =
                    inv_sub_byte(state[127-8*(r+4*((c+4-r)%4)) -: 8]) ^
                    round_key[127-8*(r+4*c) -: 8];
            end
        end
        result = ark;
        if (!is_last) begin
            for (int c = 0; c < 4; c++) begin
                result[127-32*c -: 32] = inv_mix_col(ark[127-32*c -: 32]);
            end
        end
    end

endmodule

// File: rtl/aes_decrypt_core.sv
// Iterative AES inverse cipher, one inverse round per clock.
// Define AES_DEC_KEY_LATCH_EN to capture the key schedule on the accept edge.
//
//   state | meaning
//   IDLE  | ready=1, waiting for start; accept applies rk[Nr]
//   ROUND | full inverse round with rk[rnd], rnd counts Nr-1 down to 1
//   FINAL | last round without InvMixColumns using rk[0]; pulses done
module aes_decrypt_core
    import aes_pkg::*;
#(
    parameter int Nk = 8,
    parameter int Nr = 14,
    parameter int Nb = 4
) (
    input  logic                clk,
    input  logic                rst,
    aes_decrypt_core_if.slave   bus
);

    localparam int KW = 128 * (Nr + 1);

    if (Nr != nr_from_nk(Nk) || Nb != 4 || !(Nk == 4 || Nk == 6 || Nk == 8)) begin : g_param_check
        $error("aes_decrypt_core: unsupported Nk=%0d Nr=%0d Nb=%0d", Nk, Nr, Nb);
    end

    dec_state_e   state_q, state_d;
    logic [127:0] s_q;
    logic [3:0]   rnd_q;
    logic         ready_q;
    logic         done_q;
    logic [127:0] out_q;
    logic [KW-1:0] w_src;
    logic [3:0]   rk_sel;
    logic [127:0] round_key;
    logic [127:0] round_out;

`ifdef AES_DEC_KEY_LATCH_EN
    logic [KW-1:0] w_q;
    assign w_src = w_q;
`else
    assign w_src = bus.w;
`endif

    assign rk_sel    = (state_q == FINAL) ? 4'd0 : rnd_q;
    assign round_key = w_src[KW-1-128*int'(rk_sel) -: 128];

    aes_inv_round u_inv_round (
        .state     (s_q),
        .round_key (round_key),
        .is_last   (state_q == FINAL),
        .result    (round_out)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = ROUND;
            ROUND:   if (rnd_q == 4'd1) state_d = FINAL;
            FINAL:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            s_q     <= '0;
            rnd_q   <= '0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            out_q   <= '0;
`ifdef AES_DEC_KEY_LATCH_EN
            w_q     <= '0;
`endif
        end else begin
            state_q <= state_d;
            done_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        // rk[Nr] sits in the bottom 128 bits of the live schedule.
                        s_q     <= bus.in ^ bus.w[127:0];
                        rnd_q   <= 4'(Nr - 1);
                        ready_q <= 1'b0;
`ifdef AES_DEC_KEY_LATCH_EN
                        w_q     <= bus.w;
`endif
                    end
                end
                ROUND: begin
                    s_q   <= round_out;
                    rnd_q <= rnd_q - 4'd1;
                end
                FINAL: begin
                    out_q   <= round_out;
                    done_q  <= 1'b1;
                    ready_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.ready = ready_q;
    assign bus.done  = done_q;
    assign bus.out   = out_q;

endmodule

// File: tb/tb_aes_decrypt_core.sv
// Directed bench for aes_decrypt_core: AES-128/192/256 known-answer vectors,
// back-to-back blocks, mid-block reset and (with AES_DEC_KEY_LATCH_EN) key latching.
module tb_aes_decrypt_core;
    import aes_pkg::*;

    logic clk;
    logic rst;
    logic start_drv;
    logic [127:0] ct_drv;
    int   sel;
    logic [128*15-1:0] w8_drv;
    logic [128*11-1:0] w4_drv;
    logic [128*13-1:0] w6_drv;

    logic         rdy, dn;
    logic [127:0] o;

    int n_checks = 0;
    int n_fail   = 0;

    aes_decrypt_core_if #(.NR(14)) if8 ();
    aes_decrypt_core_if #(.NR(10)) if4 ();
    aes_decrypt_core_if #(.NR(12)) if6 ();

    assign if8.start = start_drv && (sel == 8);
    assign if4.start = start_drv && (sel == 4);
    assign if6.start = start_drv && (sel == 6);
    assign if8.in = ct_drv;
    assign if4.in = ct_drv;
    assign if6.in = ct_drv;
    assign if8.w  = w8_drv;
    assign if4.w  = w4_drv;
    assign if6.w  = w6_drv;

    aes_decrypt_core #(.Nk(8), .Nr(14), .Nb(4)) u_dut8 (.clk(clk), .rst(rst), .bus(if8));
    aes_decrypt_core #(.Nk(4), .Nr(10), .Nb(4)) u_dut4 (.clk(clk), .rst(rst), .bus(if4));
    aes_decrypt_core #(.Nk(6), .Nr(12), .Nb(4)) u_dut6 (.clk(clk), .rst(rst), .bus(if6));

    always_comb begin
        rdy = 1'b0;
        dn  = 1'b0;
        o   = '0;
        case (sel)
            4: begin rdy = if4.ready; dn = if4.done; o = if4.out; end
            6: begin rdy = if6.ready; dn = if6.done; o = if6.out; end
            default: begin rdy = if8.ready; dn = if8.done; o = if8.out; end
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int           nk;
        logic [127:0] ct;
        logic [127:0] pt;
        int           lat;
    } vec_t;

    function automatic logic [31:0] sub_word(input logic [31:0] x);
        return {sub_byte(x[31:24]), sub_byte(x[23:16]), sub_byte(x[15:8]), sub_byte(x[7:0])};
    endfunction

    // Reference key expansion; word i of the schedule lands at [1919-32*i -: 32].
    function automatic logic [1919:0] expand(input int nk, input logic [255:0] key);
        logic [31:0]   wd [60];
        logic [31:0]   t;
        logic [7:0]    rc;
        logic [1919:0] r;
        int            total;
        total = 4 * (nk + 7);
        rc = 8'h01;
        r  = '0;
        for (int i = 0; i < 60; i++) wd[i] = '0;
        for (int i = 0; i < nk; i++) wd[i] = key[255-32*i -: 32];
        for (int i = nk; i < total; i++) begin
            t = wd[i-1];
            if (i % nk == 0) begin
                t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xtime(rc);
            end else if (nk > 6 && i % nk == 4) begin
                t = sub_word(t);
            end
            wd[i] = wd[i-nk] ^ t;
        end
        for (int i = 0; i < 60; i++) r[1919-32*i -: 32] = wd[i];
        return r;
    endfunction

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Present ct with start for one accept edge; lat counts edges from accept to done visible.
    task automatic run_block(input int nk, input logic [127:0] ct,
                             output logic [127:0] pt, output int lat);
        sel       = nk;
        ct_drv    = ct;
        start_drv = 1'b1;
        @(posedge clk); #1;
        start_drv = 1'b0;
        ct_drv    = 128'h0badc0de0badc0de0badc0de0badc0de;
        lat = 1;
        while (!dn && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        pt = o;
    endtask

    localparam logic [255:0] KEY_FIPS = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] KEY_SP   = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] PT_FIPS  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_256   = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] CT_SP1   = 128'hf3eed1bdb5d2a03c064b5a7e3db181f8;
    localparam logic [127:0] PT_SP1   = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] CT_SP2   = 128'h591ccb10d410ed26dc5ba74a31362870;
    localparam logic [127:0] PT_SP2   = 128'hae2d8a571e03ac9c9eb76fac45af8e51;

    initial begin
        vec_t          vecs [3];
        logic [1919:0] k8, k4, k6, ksp;
        logic [127:0]  pt;
        int            lat, gap, n_done;

        vecs[0] = '{nk: 8, ct: CT_256, pt: PT_FIPS, lat: 15};
        vecs[1] = '{nk: 4, ct: 128'h69c4e0d86a7b0430d8cdb78070b4c55a, pt: PT_FIPS, lat: 11};
        vecs[2] = '{nk: 6, ct: 128'hdda97ca4864cdfe06eaf70a0ec0d7191, pt: PT_FIPS, lat: 13};

        k8  = expand(8, KEY_FIPS);
        k4  = expand(4, KEY_FIPS);
        k6  = expand(6, KEY_FIPS);
        ksp = expand(8, KEY_SP);
        w8_drv = k8;
        w4_drv = k4[1919 -: 1408];
        w6_drv = k6[1919 -: 1664];

        rst = 1'b0;
        start_drv = 1'b0;
        ct_drv = '0;
        sel = 8;
        repeat (3) @(posedge clk);
        #1;
        check("reset ready", 128'(rdy), 128'd1);
        check("reset done",  128'(dn),  128'd0);
        check("reset out",   o,         128'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 3; i++) begin
            run_block(vecs[i].nk, vecs[i].ct, pt, lat);
            check($sformatf("latency nk=%0d", vecs[i].nk), 128'(lat), 128'(vecs[i].lat));
            check($sformatf("plaintext nk=%0d", vecs[i].nk), pt, vecs[i].pt);
            check($sformatf("ready at done nk=%0d", vecs[i].nk), 128'(rdy), 128'd1);
            @(posedge clk); #1;
            check($sformatf("done one cycle nk=%0d", vecs[i].nk), 128'(dn), 128'd0);
        end

        // Back-to-back with start held high and extra starts while busy.
        sel = 8;
        w8_drv = ksp;
        @(posedge clk); #1;
        ct_drv = CT_SP1;
        start_drv = 1'b1;
        @(posedge clk); #1;
        ct_drv = CT_SP2;
        lat = 1;
        while (!dn && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("b2b first latency", 128'(lat), 128'd15);
        check("b2b first plaintext", o, PT_SP1);
        check("b2b ready at done", 128'(rdy), 128'd1);
        @(posedge clk); #1;
        ct_drv = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;
        gap = 1;
        check("b2b second accepted", 128'(rdy), 128'd0);
        repeat (3) begin
            @(posedge clk); #1;
            gap++;
        end
        start_drv = 1'b0;
        check("b2b out held", o, PT_SP1);
        while (!dn && gap < 40) begin
            @(posedge clk); #1;
            gap++;
        end
        check("b2b done spacing", 128'(gap), 128'd15);
        check("b2b second plaintext", o, PT_SP2);

        // Reset in the middle of a block.
        w8_drv = k8;
        @(posedge clk); #1;
        ct_drv = CT_256;
        start_drv = 1'b1;
        @(posedge clk); #1;
        start_drv = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("midreset ready", 128'(rdy), 128'd1);
        check("midreset done",  128'(dn),  128'd0);
        check("midreset out",   o,         128'd0);
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        n_done = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (dn) n_done++;
        end
        check("midreset no done", 128'(n_done), 128'd0);
        run_block(8, CT_256, pt, lat);
        check("after reset plaintext", pt, PT_FIPS);
        @(posedge clk); #1;

`ifdef AES_DEC_KEY_LATCH_EN
        sel = 8;
        ct_drv = CT_256;
        start_drv = 1'b1;
        @(posedge clk); #1;
        start_drv = 1'b0;
        @(posedge clk); #1;
        w8_drv = '0;
        lat = 2;
        while (!dn && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latched key latency", 128'(lat), 128'd15);
        check("latched key plaintext", o, PT_FIPS);
        w8_drv = k8;
        @(posedge clk); #1;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
